reaction_ctrl: RTL

//  Sequencer for the 1 ms reaction-time counter (14-bit count, go/clr inputs).

---
 rtl/reaction_pkg.sv | 21 ++
 rtl/lfsr16.sv | 30 +++
 rtl/reaction_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time sequencer.
package reaction_pkg;

  localparam int unsigned COUNT_W   = 14;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    TEST,
    DONE,
    EARLY,
    TIMEOUT
  } state_e;

  // Fibonacci step, taps 16,14,13,11.
  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used to randomise the pre-stimulus wait.
module lfsr16
  import reaction_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] q
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_next(lfsr_q);
    // Recover from an illegal all-zero state rather than locking up.
    if (lfsr_q == 16'h0000) begin
      lfsr_d = LFSR_SEED;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction-test sequencer: random wait, stimulus, capture of the user's reaction time.
// Optional macro BEST_TIME_EN adds a best-result register on best_time.
module reaction_ctrl
  import reaction_pkg::*;
#(
  parameter int unsigned TICK_DVSR   = 100000,
  parameter int unsigned MIN_WAIT_MS = 2000,
  parameter int unsigned RAND_BITS   = 12,
  parameter int unsigned TIMEOUT_MS  = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               clear,
  input  logic [COUNT_W-1:0] count_i,
  output logic               timer_go,
  output logic               timer_clr,
  output logic               stim_led,
  output logic               busy,
  output logic [COUNT_W-1:0] result,
  output logic               result_valid,
  output logic               early,
  output logic               timeout,
  output logic [COUNT_W-1:0] best_time
);

  localparam int unsigned WAIT_W = $clog2(MIN_WAIT_MS + (2 ** RAND_BITS));
  localparam int unsigned TICK_W = (TICK_DVSR > 1) ? $clog2(TICK_DVSR) : 1;

  localparam logic [TICK_W-1:0]  TICK_LAST   = TICK_W'(TICK_DVSR - 1);
  localparam logic [WAIT_W-1:0]  WAIT_MIN    = WAIT_W'(MIN_WAIT_MS);
  localparam logic [COUNT_W-1:0] TIMEOUT_VAL = COUNT_W'(TIMEOUT_MS);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [COUNT_W-1:0]  result_q, result_d;
  logic [15:0]         lfsr;
  logic                load_wait;
  logic                tick_wrap;
  logic                enter_done;
  logic                unused_lfsr;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr)
  );

  // Only the low RAND_BITS feed the delay; fold the rest so nothing dangles.
  assign unused_lfsr = ^lfsr;
  assign tick_wrap   = (tick_q == TICK_LAST);

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    tick_d     = tick_q;
    result_d   = result_q;
    load_wait  = 1'b0;
    enter_done = 1'b0;

    if (clear) begin
      state_d  = IDLE;
      result_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            load_wait = 1'b1;
          end
        end
        WAIT: begin
          if (stop) begin
            state_d = EARLY;
          end else if (tick_wrap) begin
            tick_d = '0;
            wait_d = wait_q - WAIT_W'(1);
            if (wait_q == WAIT_W'(1)) begin
              state_d = TEST;
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
        TEST: begin
          if (stop) begin
            state_d    = DONE;
            result_d   = count_i;
            enter_done = 1'b1;
          end else if (count_i >= TIMEOUT_VAL) begin
            state_d  = TIMEOUT;
            result_d = TIMEOUT_VAL;
          end
        end
        DONE, EARLY, TIMEOUT: begin
          if (start) begin
            load_wait = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    if (load_wait) begin
      state_d = WAIT;
      wait_d  = WAIT_MIN + WAIT_W'(lfsr[RAND_BITS-1:0]);
      tick_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      wait_q   <= '0;
      tick_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      tick_q   <= tick_d;
      result_q <= result_d;
    end
  end

`ifdef BEST_TIME_EN
  logic [COUNT_W-1:0] best_q, best_d;

  always_comb begin
    best_d = best_q;
    if (enter_done && (count_i < best_q)) begin
      best_d = count_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      best_q <= '1;
    end else begin
      best_q <= best_d;
    end
  end

  assign best_time = best_q;
`else
  logic unused_enter_done;
  assign unused_enter_done = enter_done;
  assign best_time         = '1;
`endif

  // Counter is held clear everywhere but TEST so it starts from 0 at stimulus.
  assign timer_go     = (state_q == TEST);
  assign timer_clr    = (state_q != TEST);
  assign stim_led     = (state_q == TEST);
  assign busy         = (state_q == WAIT) || (state_q == TEST);
  assign result_valid = (state_q == DONE);
  assign early        = (state_q == EARLY);
  assign timeout      = (state_q == TIMEOUT);
  assign result       = result_q;

endmodule
